// File: rtl/rr_mux_select.sv
// rr_mux_select: round-robin arbiter producing the registered 2-bit select
// for a downstream 4:1 mux, plus a one-hot grant back to the four requesters.
// The select is held until the mux consumer accepts the word (ready), or the
// requester withdraws. Optional grant timeout: define RR_MUX_TIMEOUT_EN.
module rr_mux_select #(
    parameter int TIMEOUT = 15,
    parameter int CNTW    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       ready,
    output logic [1:0] s,
    output logic [3:0] grant,
    output logic       valid,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // The counter must be able to represent TIMEOUT; a bad pairing leaves
    // this empty block as a visible marker in the elaborated hierarchy.
    if (TIMEOUT >= (1 << CNTW)) begin : g_timeout_too_wide_for_cntw
    end

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] s_q, s_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic       to_pulse;

`ifdef RR_MUX_TIMEOUT_EN
    logic [CNTW-1:0] cnt_q, cnt_d;
`endif

    // First set request bit searching upward from p, wrapping mod 4.
    // Returns {found, index}.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!res[2] && r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Next-state logic: IDLE arbitration, and release/re-arbitration in GRANT.
    always_comb begin
        logic       rel;
        logic [2:0] win;
        state_d  = state_q;
        ptr_d    = ptr_q;
        s_d      = s_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        to_pulse = 1'b0;
        rel      = 1'b0;
        win      = 3'b000;
`ifdef RR_MUX_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                win = pick(req, ptr_q);
                if (win[2]) begin
                    s_d     = win[1:0];
                    grant_d = 4'b0001 << win[1:0];
                    valid_d = 1'b1;
                    state_d = ST_GRANT;
`ifdef RR_MUX_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: begin
                // Transfer or withdrawal both hand the slot on.
                rel = ready || !req[s_q];
`ifdef RR_MUX_TIMEOUT_EN
                if (!rel) begin
                    if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                        rel      = 1'b1;
                        to_pulse = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                if (rel) begin
                    // Re-arbitrate from the slot after the winner, no bubble.
                    ptr_d = s_q + 2'd1;
                    win   = pick(req, s_q + 2'd1);
                    if (win[2]) begin
                        s_d     = win[1:0];
                        grant_d = 4'b0001 << win[1:0];
`ifdef RR_MUX_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        grant_d = 4'b0000;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            s_q     <= 2'd0;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

`ifdef RR_MUX_TIMEOUT_EN
    // Wait counter for the current grant.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign timeout = to_pulse;
`else
    assign timeout = 1'b0;
`endif

    assign s     = s_q;
    assign grant = grant_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rr_mux_select.sv
// Directed testbench for rr_mux_select. Covers the timeout feature when
// RR_MUX_TIMEOUT_EN is defined (instantiated with TIMEOUT=4), otherwise the
// hold-indefinitely behaviour.
module tb_rr_mux_select;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       ready;
    logic [1:0] s;
    logic [3:0] grant;
    logic       valid;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rr_mux_select #(.TIMEOUT(4), .CNTW(4)) dut (
        .clk(clk), .reset(reset), .req(req), .ready(ready),
        .s(s), .grant(grant), .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] exp_grant,
                       input logic [1:0] exp_s, input logic exp_valid,
                       input logic exp_to);
        n_tests++;
        if (grant !== exp_grant || s !== exp_s || valid !== exp_valid || timeout !== exp_to) begin
            n_fail++;
            $display("FAIL %s: got s=%b grant=%b valid=%b timeout=%b, want s=%b grant=%b valid=%b timeout=%b",
                     name, s, grant, valid, timeout, exp_s, exp_grant, exp_valid, exp_to);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 4'b0000; ready = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_state", 4'b0000, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_single_hold();
        do_reset();
        req = 4'b0001; ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("single_hold", 4'b0001, 2'b00, 1'b1, 1'b0);
        end
        ready = 1'b1; step(); ready = 1'b0;
        chk("single_rewin", 4'b0001, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] es;
        do_reset();
        req = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            es = 2'(i);
            chk("b2b_rotate", 4'b0001 << es, es, 1'b1, 1'b0);
        end
        ready = 1'b0; req = 4'b0000;
    endtask

    task automatic test_wrap_and_idle();
        do_reset();
        req = 4'b0100; ready = 1'b0;
        step();
        chk("grant_ch2", 4'b0100, 2'b10, 1'b1, 1'b0);
        req = 4'b0111; ready = 1'b1;
        step(); ready = 1'b0;
        chk("wrap_to_0", 4'b0001, 2'b00, 1'b1, 1'b0);
        req = 4'b0000; ready = 1'b1;
        step(); ready = 1'b0;
        chk("drop_to_idle", 4'b0000, 2'b00, 1'b0, 1'b0);
        step();
        chk("idle_hold_s", 4'b0000, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0010; ready = 1'b0;
        step();
        chk("grant_ch1", 4'b0010, 2'b01, 1'b1, 1'b0);
        req = 4'b1001;
        step();
        chk("withdraw_to_3", 4'b1000, 2'b11, 1'b1, 1'b0);
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0011; ready = 1'b0;
`ifdef RR_MUX_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_hold", 4'b0001, 2'b00, 1'b1, (i == 3));
        end
        step();
        chk("to_next", 4'b0010, 2'b01, 1'b1, 1'b0);
        // ready on the would-be timeout cycle is a normal transfer.
        for (int i = 0; i < 3; i++) step();
        ready = 1'b1;
        chk("to_ready_wins", 4'b0010, 2'b01, 1'b1, 1'b0);
        step(); ready = 1'b0;
        chk("to_ready_next", 4'b0001, 2'b00, 1'b1, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk("no_to_hold", 4'b0001, 2'b00, 1'b1, 1'b0);
        end
`endif
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100; ready = 1'b0;
        step();
        chk("pre_reset_ch2", 4'b0100, 2'b10, 1'b1, 1'b0);
        req = 4'b1111; ready = 1'b1; reset = 1'b1;
        step();
        chk("mid_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        reset = 1'b0; ready = 1'b0;
        step();
        chk("post_reset_ch0", 4'b0001, 2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; req = 4'b0000; ready = 1'b0;
        test_reset();
        test_single_hold();
        test_back_to_back();
        test_wrap_and_idle();
        test_withdraw();
        test_timeout();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
